// File: rtl/buffer_uart_tx.sv
// Drains words from the sample buffer and sends each one as DATA_WIDTH/8
// 8N1 UART frames, least-significant byte first.
module buffer_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_read,
  output logic                  tx,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [DIV_WIDTH-1:0] BAUD_LAST = DIV_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]        BYTE_LAST = BW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] word_sh_s;
  logic                  tx_q, tx_d;
  logic                  read_q, read_d;
  logic                  busy_q, busy_d;
  logic                  baud_end_s;

  // State register; the reset value forces the line idle-high immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; the word is latched only on the IDLE pop.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    word_d     = word_q;
    read_d     = 1'b0;
    baud_end_s = (baud_q == BAUD_LAST);
    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          word_d  = data_in;
          read_d  = 1'b1;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_d = '0;
          bit_d  = 3'd0;
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + BW'(1);
            state_d = START;
          end
        end else begin
          baud_d = baud_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line value for the upcoming cycle, derived from the next state so tx is a flop.
  always_comb begin
    word_sh_s = word_d >> {byte_d, bit_d};
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = word_sh_s[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign data_in_read = read_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Self-checking bench for buffer_uart_tx with CLKS_PER_BIT=4: a frame-level
// model checked every cycle, a UART receiver, and literal byte/timing checks.
module tb_buffer_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * 4 * C;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_read;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad   = 0;

  buffer_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(C), .DIV_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_read  (data_in_read),
    .tx            (tx),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Word-level model: after a pop, cycle t of the 160-cycle word maps to a frame bit.
  logic        m_act  = 1'b0;
  logic        m_read = 1'b0;
  int          m_t    = 0;
  logic [31:0] m_word = 32'h0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_act  = 1'b0;
      m_read = 1'b0;
      m_t    = 0;
    end else begin
      m_read = 1'b0;
      if (m_act) begin
        if (m_t == FRAME - 1) m_act = 1'b0;
        else m_t++;
      end else if (data_in_valid) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_word = data_in;
        m_read = 1'b1;
      end
    end
  end

  function automatic logic model_tx();
    int k;
    int b;
    if (!m_act) return 1'b1;
    k = m_t / (10 * C);
    b = (m_t % (10 * C)) / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_word[8 * k + b - 1];
  endfunction

  // Statistics and per-cycle comparison, sampled on the falling edge.
  int cyc      = 0;
  int rd_cnt   = 0;
  int busy_cnt = 0;
  int low_cnt  = 0;
  int rd_cyc[$];
  int rd_low[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("cyc_tx",   32'(tx),           32'(model_tx()));
    chk("cyc_busy", 32'(busy),         32'(m_act));
    chk("cyc_read", 32'(data_in_read), 32'(m_read));
    if (data_in_read === 1'b1) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      rd_low.push_back(low_cnt);
    end
    if (busy === 1'b1) busy_cnt++;
    else if (rst) low_cnt++;
  end

  // UART receiver: samples mid-bit, discards a frame cut by reset.
  logic [7:0] rxq[$];
  logic [7:0] rx_b = 8'h00;
  logic       rx_on = 1'b0;
  int         rx_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
        rx_b   = 8'h00;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2) begin
        if (rx_cnt / C >= 1 && rx_cnt / C <= 8) begin
          rx_b[rx_cnt / C - 1] = tx;
        end else if (rx_cnt / C == 9) begin
          chk("stop_bit", 32'(tx), 32'd1);
          rxq.push_back(rx_b);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic clear_stats();
    rxq.delete();
    rd_cyc.delete();
    rd_low.delete();
    rd_cnt   = 0;
    busy_cnt = 0;
    low_cnt  = 0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_bytes(input string nm, input int n, input logic [127:0] e);
    chk({nm, "_count"}, 32'(rxq.size()), 32'(n));
    for (int i = 0; i < n && i < rxq.size(); i++) begin
      chk($sformatf("%s_b%0d", nm, i), 32'(rxq[i]), 32'(e[8*i +: 8]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  logic [31:0] fifo[$];
  logic        rdv;

  initial begin
    rst           = 1'b0;
    data_in_valid = 1'b1;
    data_in       = 32'hDEADBEEF;

    // Reset held with valid high: line idle, no pop.
    repeat (5) @(negedge clk);
    chk("rst_tx",   32'(tx),           32'd1);
    chk("rst_read", 32'(data_in_read), 32'd0);
    chk("rst_busy", 32'(busy),         32'd0);

    // Single word popped on the first edge after release.
    @(posedge clk); #2;
    rst     = 1'b1;
    data_in = 32'hA5C30F81;
    clear_stats();
    @(posedge clk); #2;
    data_in_valid = 1'b0;
    data_in       = 32'h0;
    wait_done("w1");
    chk_bytes("w1", 4, 128'hA5C30F81);
    chk("w1_reads", 32'(rd_cnt),   32'd1);
    chk("w1_busy",  32'(busy_cnt), 32'd160);

    // Back-to-back words with valid held high.
    clear_stats();
    @(posedge clk); #2;
    data_in       = 32'h00000001;
    data_in_valid = 1'b1;
    @(posedge clk); #2;
    data_in = 32'hFFFFFFFF;
    repeat (161) @(posedge clk);
    #2;
    data_in_valid = 1'b0;
    wait_done("b2b");
    chk_bytes("b2b", 8, 128'hFFFFFFFF_00000001);
    chk("b2b_reads", 32'(rd_cnt), 32'd2);
    chk("b2b_gap",  32'((rd_cyc.size() > 1) ? rd_cyc[1] - rd_cyc[0] : 0), 32'd161);
    chk("b2b_idle", 32'((rd_low.size() > 1) ? rd_low[1] - rd_low[0] : 0), 32'd1);

    // Input churn during transmission must not disturb the latched word.
    clear_stats();
    @(posedge clk); #2;
    data_in       = 32'h12345678;
    data_in_valid = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 150; i++) begin
      data_in       = {4{8'(i)}};
      data_in_valid = (i % 2 == 0);
      @(posedge clk); #2;
    end
    data_in_valid = 1'b0;
    wait_done("stab");
    chk_bytes("stab", 4, 128'h12345678);
    chk("stab_reads", 32'(rd_cnt), 32'd1);

    // Reset during byte 2 bit 3, then a fresh word.
    clear_stats();
    @(posedge clk); #2;
    data_in       = 32'hCAFEF00D;
    data_in_valid = 1'b1;
    @(posedge clk); #2;
    data_in_valid = 1'b0;
    repeat (97) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx",   32'(tx),           32'd1);
    chk("mid_rst_busy", 32'(busy),         32'd0);
    chk("mid_rst_read", 32'(data_in_read), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("post_rst_busy",  32'(busy),   32'd0);
    chk("post_rst_reads", 32'(rd_cnt), 32'd1);
    data_in       = 32'h0BADBEEF;
    data_in_valid = 1'b1;
    @(posedge clk); #2;
    data_in_valid = 1'b0;
    wait_done("rst");
    chk_bytes("rst", 6, 128'h0BADBEEF_F00D);
    chk("rst_reads", 32'(rd_cnt), 32'd2);

    // Small buffer stand-in: pops on strobe, updates data on the edge ending it.
    clear_stats();
    fifo.push_back(32'h11111111);
    fifo.push_back(32'h22222222);
    fifo.push_back(32'h33333333);
    @(posedge clk); #2;
    data_in_valid = 1'b1;
    data_in       = fifo[0];
    for (int n = 0; n < 600 && (fifo.size() > 0 || busy === 1'b1); n++) begin
      @(negedge clk);
      rdv = data_in_read;
      @(posedge clk); #2;
      if (rdv && fifo.size() > 0) void'(fifo.pop_front());
      data_in_valid = (fifo.size() > 0);
      data_in       = (fifo.size() > 0) ? fifo[0] : 32'h0;
    end
    wait_done("buf");
    chk_bytes("buf", 12, 128'h33333333_22222222_11111111);
    chk("buf_reads",   32'(rd_cnt),      32'd3);
    chk("buf_drained", 32'(fifo.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_uart_tx.md
Name: buffer_uart_tx

Overview:
- Drain side of the word buffer. Pops 32-bit words over the buffer's valid/read output handshake and serialises each word as DATA_WIDTH/8 UART frames on a single TX line, least-significant byte first.
- Sits between the sample buffer and the board's UART pin. Streams processed microphone data to the host PC.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8 (BYTES = DATA_WIDTH/8).
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2 .. 2^DIV_WIDTH-1.
- DIV_WIDTH, 16, width of baud counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  word presented by buffer (buffer data_out).
- data_in_valid  input  1  buffer holds a word (buffer data_out_valid).
- data_in_read  output  1  one-cycle pop strobe (to buffer data_out_read).
- tx  output  1  UART serial out, idle high, 8N1.
- busy  output  1  high while a word is being serialised.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst=0, immediately and regardless of clk: tx=1, data_in_read=0, busy=0, state=IDLE, all counters 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - Sampled data_in_valid=1 at edge E: word register <= data_in, data_in_read <= 1, tx <= 0, baud cnt <= 0, bit idx <= 0, byte idx <= 0, state <= START.
- data_in_read:
  - Registered; high for exactly the one cycle after E, then 0.
  - Never asserted outside IDLE->START transition, so at most one pop per word.
  - Buffer gives read priority over write, so the strobe must never exceed one cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = current byte bit[bit idx], LSB first, each bit CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then if byte idx < BYTES-1: byte idx+1, go to START with no extra gap.
  - Else: go to IDLE.
- Byte order: byte k = word[8k+7:8k], k=0 first.
- Baud counter counts 0..CLKS_PER_BIT-1; wraps to 0 on each bit boundary. No fractional correction.
- tx is registered (glitch-free). Its first low cycle is the cycle after E.
- busy:
  - Registered, equals (state != IDLE).
  - Rises the cycle after E; falls the cycle after the last stop bit completes.
- Throughput:
  - Back-to-back words: exactly one IDLE cycle (tx=1) between the last stop bit of word n and the start bit of word n+1.
  - Word period = 10*BYTES*CLKS_PER_BIT + 1 cycles.
- data_in and data_in_valid are ignored outside IDLE. The latched word cannot be corrupted by buffer activity.
- Buffer updates data_out on the edge ending the data_in_read cycle. That value is not sampled before the next IDLE, so no stale re-read.
- data_in_valid low in IDLE: remain IDLE, tx=1, no strobe.
- Reset mid-operation: frame aborted, tx forced high at once. The popped word is discarded, not retransmitted. After release, start only on a fresh data_in_valid.
- No parity, no flow control, no error outputs.

Test Plan:
- Reset: hold rst=0 with data_in_valid=1 -> tx=1, data_in_read=0, busy=0 throughout. rst released -> first start bit begins 1 cycle after first valid edge.
- Single word, CLKS_PER_BIT=4, data_in=0xA5C30F81 valid for one pop -> data_in_read high exactly 1 cycle. tx decodes bytes 0x81,0x0F,0xC3,0xA5. Each frame 40 cycles (start 0, LSB first, stop 1). busy high 160 cycles.
- Back-to-back: data_in_valid held 1, words 0x00000001 then 0xFFFFFFFF -> two read strobes 161 cycles apart. Exactly one idle-high cycle between words. Bytes 01,00,00,00,FF,FF,FF,FF.
- Input stability: change data_in and toggle data_in_valid every cycle during transmission of 0x12345678 -> output still 78,56,34,12. No extra data_in_read.
- Reset mid-DATA (byte 2, bit 3) -> tx=1 same cycle, busy=0. No retransmission. Next word after release sent intact.
- Integration with buffer block: write 3 words (0x11111111, 0x22222222, 0x33333333) via its input ack handshake -> all 12 bytes received in order. Buffer drains to data_out_valid=0, no pop while empty.
